uart_tx_fifo: RTL and testbench

UART transmitter with a small input FIFO, the transmit-side companion to the board's UART receive path. It accepts bytes over a valid/ready handshake, buffers them, and serialises each byte as an 8N1 frame on a single line: idle high, one start bit, eight data bits LSB first, one stop bit. It sits between on-board logic and the serial TX pin and runs at the same 100 MHz board clock and 57600-baud rate as the receiver.

---
 rtl/uart_tx_fifo_if.sv | 9 +
 rtl/uart_tx_fifo.sv | 153 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte handshake between on-board logic (master) and the UART transmitter (slave).
interface uart_tx_fifo_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small circular FIFO over a valid/ready handshake.
// Queued bytes are sent as contiguous frames with no idle gap between them.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 1736,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                        CLK,
    input  logic                        reset,
    uart_tx_fifo_if.slave               tx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        UartTx
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              line_q, line_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ready_q, ready_d;
    logic [7:0]        fifo_mem_q [FIFO_DEPTH];

    logic       push;
    logic       pop;
    logic       baud_done;
    logic       fifo_has_data;
    logic [7:0] head_byte;

    // The source only sees ready_q, so a push is judged against the registered flag.
    assign push          = tx.tx_valid && ready_q;
    assign baud_done     = (baud_q == BAUD_LAST);
    assign fifo_has_data = (count_q != '0);
    assign head_byte     = fifo_mem_q[rd_ptr_q];

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_done ? '0 : baud_q + BAUD_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        line_d    = line_q;
        pop       = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                line_d = 1'b1;
                if (fifo_has_data) begin
                    pop     = 1'b1;
                    shift_d = head_byte;
                    line_d  = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    bit_idx_d = 3'd0;
                    line_d    = shift_q[0];
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (baud_done) begin
                    if (bit_idx_q == 3'd7) begin
                        line_d  = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                        line_d    = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (baud_done) begin
                    if (fifo_has_data) begin
                        pop     = 1'b1;
                        shift_d = head_byte;
                        line_d  = 1'b0;
                        state_d = START;
                    end else begin
                        line_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                line_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != COUNT_FULL);
    end

    // NOTE: state flops use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            line_q    <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            line_q    <= line_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
        end
    end

    // NOTE: storage has no reset; cleared pointers and count make stale entries unreachable.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= tx.tx_data;
        end
    end

    assign tx.tx_ready = ready_q;
    assign tx_busy     = (state_q != IDLE);
    assign fifo_count  = count_q;
    assign UartTx      = line_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (short bit time / shallow FIFO and a deeper one)
// compared every cycle against a frame-level model, plus table vectors and corner sequences.
module tb_uart_tx_fifo;
    localparam int C0 = 4;
    localparam int D0 = 2;
    localparam int C1 = 8;
    localparam int D1 = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    uart_tx_fifo_if if0 ();
    uart_tx_fifo_if if1 ();

    logic       busy0, line0, busy1, line1;
    logic [1:0] cnt0;
    logic [2:0] cnt1;

    uart_tx_fifo #(.CLKS_PER_BIT(C0), .FIFO_DEPTH(D0)) dut0 (
        .CLK(clk), .reset(rst_n), .tx(if0),
        .tx_busy(busy0), .fifo_count(cnt0), .UartTx(line0)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(C1), .FIFO_DEPTH(D1)) dut1 (
        .CLK(clk), .reset(rst_n), .tx(if1),
        .tx_busy(busy1), .fifo_count(cnt1), .UartTx(line1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a list of queued bytes and the elapsed time of the current frame.
    int         m_c [2] = '{C0, C1};
    int         m_d [2] = '{D0, D1};
    logic [7:0] m_mem [2][16];
    int         m_head [2];
    int         m_size [2];
    bit         m_act [2];
    int         m_t [2];
    logic [7:0] m_cur [2];

    logic [7:0] src0 [$];
    logic [7:0] src1 [$];
    int         vprob = 100;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_head[k] = 0;
            m_size[k] = 0;
            m_act[k]  = 1'b0;
            m_t[k]    = 0;
            m_cur[k]  = 8'h00;
        end
    endtask

    task automatic model_pop(input int k);
        m_cur[k]  = m_mem[k][m_head[k]];
        m_head[k] = (m_head[k] + 1) % 16;
        m_size[k] = m_size[k] - 1;
        m_act[k]  = 1'b1;
        m_t[k]    = 0;
    endtask

    task automatic model_step(input int k, input logic valid, input logic [7:0] data,
                              output bit accepted);
        accepted = valid && (m_size[k] != m_d[k]);
        if (!m_act[k]) begin
            if (m_size[k] > 0) model_pop(k);
        end else begin
            m_t[k] = m_t[k] + 1;
            if (m_t[k] == 10 * m_c[k]) begin
                if (m_size[k] > 0) begin
                    model_pop(k);
                end else begin
                    m_act[k] = 1'b0;
                    m_t[k]   = 0;
                end
            end
        end
        if (accepted) begin
            m_mem[k][(m_head[k] + m_size[k]) % 16] = data;
            m_size[k] = m_size[k] + 1;
        end
    endtask

    function automatic logic exp_line(input int k);
        int t;
        int c;
        t = m_t[k];
        c = m_c[k];
        if (!m_act[k]) return 1'b1;
        if (t < c) return 1'b0;
        if (t < 9 * c) return m_cur[k][t / c - 1];
        return 1'b1;
    endfunction

    task automatic check_all();
        check("line0",  line0,        exp_line(0));
        check("busy0",  busy0,        m_act[0]);
        check("count0", cnt0,         m_size[0]);
        check("ready0", if0.tx_ready, m_size[0] != D0);
        check("line1",  line1,        exp_line(1));
        check("busy1",  busy1,        m_act[1]);
        check("count1", cnt1,         m_size[1]);
        check("ready1", if1.tx_ready, m_size[1] != D1);
    endtask

    // While the model says the FIFO is full, data is scrambled to prove it is ignored.
    task automatic drive();
        if0.tx_valid = (src0.size() > 0) && (int'($urandom_range(99)) < vprob);
        if0.tx_data  = (if0.tx_valid && m_size[0] != D0) ? src0[0] : 8'($urandom);
        if1.tx_valid = (src1.size() > 0) && (int'($urandom_range(99)) < vprob);
        if1.tx_data  = (if1.tx_valid && m_size[1] != D1) ? src1[0] : 8'($urandom);
    endtask

    task automatic tick();
        bit acc;
        drive();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step(0, if0.tx_valid, if0.tx_data, acc);
            if (acc) src0.delete(0);
            model_step(1, if1.tx_valid, if1.tx_data, acc);
            if (acc) src1.delete(0);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_idle(input int k);
        bit ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            tick();
            if (k == 0) ok = !busy0 && cnt0 == 0 && src0.size() == 0;
            else        ok = !busy1 && cnt1 == 0 && src1.size() == 0;
        end
        check("idle_timeout", ok, 1'b1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;      // {stop, data, start}, bit 0 sent first
        int         low_cycles; // length of the first low run at C0 cycles per bit
    } vec_t;

    vec_t vecs [5];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         found;
        bit         still;
        int         run;
        int         falls;
        logic       prev;
        logic [9:0] got;

        vecs[0] = '{8'hF4, 10'b1_1111_0100_0, 12};
        vecs[1] = '{8'h00, 10'b1_0000_0000_0, 36};
        vecs[2] = '{8'hFF, 10'b1_1111_1111_0, 4};
        vecs[3] = '{8'hC0, 10'b1_1100_0000_0, 28};
        vecs[4] = '{8'h55, 10'b1_0101_0101_0, 4};

        if0.tx_valid = 1'b0; if0.tx_data = 8'h00;
        if1.tx_valid = 1'b0; if1.tx_data = 8'h00;
        model_reset();

        #1 rst_n = 1'b0;
        #1;
        check("rst_line0",  line0,        1'b1);
        check("rst_busy0",  busy0,        1'b0);
        check("rst_count0", cnt0,         2'd0);
        check("rst_ready0", if0.tx_ready, 1'b1);
        check("rst_line1",  line1,        1'b1);
        check("rst_count1", cnt1,         3'd0);
        repeat (3) tick();
        rst_n = 1'b1;

        // Table vectors on the short-bit instance: sample each bit at its centre.
        for (int v = 0; v < 5; v++) begin
            wait_idle(0);
            src0.push_back(vecs[v].data);
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                tick();
                if (line0 === 1'b0) found = 1'b1;
            end
            check("fall_seen", found, 1'b1);
            if (found) begin
                got   = '0;
                run   = 0;
                still = 1'b1;
                for (int i = 0; i < 10 * C0; i++) begin
                    if (i % C0 == C0 / 2) got[i / C0] = line0;
                    if (still && line0 === 1'b0) run++;
                    else still = 1'b0;
                    tick();
                end
                check("frame_bits", got, vecs[v].frame);
                check("low_run", run, vecs[v].low_cycles);
            end
        end

        // Depth-2 full flag: ready drops only when two bytes are stored.
        wait_idle(0);
        src0.push_back(8'hA0); src0.push_back(8'hA1); src0.push_back(8'hA2);
        tick(); check("d2_cnt_n",   cnt0, 2'd1); check("d2_rdy_n",   if0.tx_ready, 1'b1);
        tick(); check("d2_cnt_n1",  cnt0, 2'd1); check("d2_rdy_n1",  if0.tx_ready, 1'b1);
        tick(); check("d2_cnt_n2",  cnt0, 2'd2); check("d2_rdy_n2",  if0.tx_ready, 1'b0);
        wait_idle(0);

        // Fill and contiguity on the depth-4 instance; the sixth byte must stall.
        wait_idle(1);
        src1.push_back(8'h7E); src1.push_back(8'h03); src1.push_back(8'h55);
        src1.push_back(8'h57); src1.push_back(8'h41); src1.push_back(8'h7E);
        tick(); check("fill_cnt_n",  cnt1, 3'd1); check("fill_busy_n", busy1, 1'b0);
        tick(); check("fill_cnt_n1", cnt1, 3'd1); check("fill_busy_n1", busy1, 1'b1);
        check("fill_line_n1", line1, 1'b0);
        tick(); check("fill_cnt_n2", cnt1, 3'd2);
        tick(); check("fill_cnt_n3", cnt1, 3'd3); check("fill_rdy_n3", if1.tx_ready, 1'b1);
        tick(); check("fill_cnt_n4", cnt1, 3'd4); check("fill_rdy_n4", if1.tx_ready, 1'b0);
        run = 4;
        for (int i = 0; i < 77; i++) begin
            tick();
            if (busy1) run++;
        end
        check("fill_cnt_pop", cnt1, 3'd3); check("fill_rdy_pop", if1.tx_ready, 1'b1);
        tick();
        if (busy1) run++;
        check("fill_cnt_refill", cnt1, 3'd4); check("fill_rdy_refill", if1.tx_ready, 1'b0);
        for (int i = 0; i < 1000 && busy1; i++) begin
            tick();
            if (busy1) run++;
        end
        check("fill_busy_run", run, 60 * C1);

        // Reset during bit 3 of 0xC0 with two bytes still queued.
        wait_idle(1);
        src1.push_back(8'hC0); src1.push_back(8'h11); src1.push_back(8'h22);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (line1 === 1'b0) found = 1'b1;
        end
        check("rst_fall_seen", found, 1'b1);
        repeat (4 * C1 + C1 / 2) tick();
        check("pre_rst_count", cnt1, 3'd2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_line",  line1,        1'b1);
        check("mid_rst_count", cnt1,         3'd0);
        check("mid_rst_busy",  busy1,        1'b0);
        check("mid_rst_ready", if1.tx_ready, 1'b1);
        model_reset();
        src0.delete();
        src1.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        falls = 0;
        prev  = line1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (prev && !line1) falls++;
            prev = line1;
        end
        check("post_rst_falls", falls, 0);
        src1.push_back(8'hFF);
        run = 0;
        for (int i = 0; i < 200 && (src1.size() > 0 || cnt1 != 0 || busy1 || i < 2); i++) begin
            tick();
            if (line1 === 1'b0) run++;
        end
        check("post_rst_ff_low", run, C1);

        // Randomised traffic with valid gaps and scrambled data while stalled.
        vprob = 70;
        for (int i = 0; i < 1500; i++) begin
            if (src0.size() < 3 && $urandom_range(5) == 0) src0.push_back(8'($urandom));
            if (src1.size() < 3 && $urandom_range(3) == 0) src1.push_back(8'($urandom));
            tick();
        end
        vprob = 100;
        wait_idle(0);
        wait_idle(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
